// File: rtl/activation_stream_unit.sv
// Multi-lane pipelined activation stage (RELU/LEAKY/HTANH/CLIP_RELU/BYPASS) on an AXI-Stream.
// Define ACT_LEAKY_ROUND_EN to round the leaky negative path half-up instead of flooring.
module activation_stream_unit #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned ALPHA_NUM   = 13,
    parameter int unsigned ALPHA_SHIFT = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [LANES-1:0]            s_axis_tkeep,
    input  logic                        s_axis_tlast,
    input  logic [2:0]                  activation_mode,
    input  logic [DATA_WIDTH-2:0]       clip_value,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [LANES-1:0]            m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [2:0]                  active_mode,
    output logic                        pkt_open
);

    // One spare bit above the full leaky product keeps the rounding add from wrapping.
    localparam int unsigned ProdW = DATA_WIDTH + $clog2(ALPHA_NUM + 1);
    localparam int unsigned WideW = ProdW + 1;

    localparam logic [2:0] ModeRelu     = 3'd0;
    localparam logic [2:0] ModeLeaky    = 3'd1;
    localparam logic [2:0] ModeHtanh    = 3'd2;
    localparam logic [2:0] ModeClipRelu = 3'd3;

    localparam logic signed [WideW-1:0] AlphaW = WideW'(ALPHA_NUM);
    localparam logic signed [WideW-1:0] SatMax = WideW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [WideW-1:0] SatMin = ~SatMax;
`ifdef ACT_LEAKY_ROUND_EN
    localparam logic signed [WideW-1:0] RoundW = WideW'(2 ** (ALPHA_SHIFT - 1));
`endif

    function automatic logic signed [WideW-1:0] act_lane(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic [2:0]                   mode,
        input logic [DATA_WIDTH-2:0]        c
    );
        logic signed [WideW-1:0] xw;
        logic signed [WideW-1:0] cw;
        logic signed [WideW-1:0] prod;
        logic signed [WideW-1:0] leaky;
        logic signed [WideW-1:0] y;
        xw   = {{(WideW - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
        cw   = {{(WideW - DATA_WIDTH + 1){1'b0}}, c};
        prod = xw * AlphaW;
`ifdef ACT_LEAKY_ROUND_EN
        prod = prod + RoundW;
`endif
        leaky = prod >>> ALPHA_SHIFT;
        case (mode)
            ModeRelu:  y = xw[WideW-1] ? '0 : xw;
            ModeLeaky: y = xw[WideW-1] ? leaky : xw;
            ModeHtanh: begin
                if (xw > cw) begin
                    y = cw;
                end else if (xw < -cw) begin
                    y = -cw;
                end else begin
                    y = xw;
                end
            end
            ModeClipRelu: begin
                if (xw[WideW-1]) begin
                    y = '0;
                end else if (xw > cw) begin
                    y = cw;
                end else begin
                    y = xw;
                end
            end
            default: y = xw;
        endcase
        return y;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [WideW-1:0] w);
        logic signed [WideW-1:0] s;
        if (w > SatMax) begin
            s = SatMax;
        end else if (w < SatMin) begin
            s = SatMin;
        end else begin
            s = w;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

    logic                        advance;
    logic                        accept;
    logic [2:0]                  eff_mode;
    logic [DATA_WIDTH-2:0]       eff_clip;
    logic signed [WideW-1:0]     s0_wide [LANES];
    logic [LANES*DATA_WIDTH-1:0] s2_data_d;

    logic                        s1_valid_q;
    logic                        s1_last_q;
    logic [LANES-1:0]            s1_keep_q;
    logic signed [WideW-1:0]     s1_data_q [LANES];
    logic                        s2_valid_q;
    logic                        s2_last_q;
    logic [LANES-1:0]            s2_keep_q;
    logic [LANES*DATA_WIDTH-1:0] s2_data_q;
    logic [2:0]                  mode_q;
    logic [DATA_WIDTH-2:0]       clip_q;
    logic                        open_q;

    assign advance       = !s2_valid_q || m_axis_tready;
    assign s_axis_tready = advance && !reset;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // First beat of a packet uses the live controls; the rest reuse the latched copy.
    assign eff_mode = open_q ? mode_q : activation_mode;
    assign eff_clip = open_q ? clip_q : clip_value;

    always_comb begin
        s2_data_d = '0;
        for (int i = 0; i < LANES; i++) begin
            s0_wide[i] = act_lane(s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH], eff_mode, eff_clip);
            s2_data_d[i*DATA_WIDTH +: DATA_WIDTH] = saturate(s1_data_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_keep_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_data_q[i] <= '0;
            end
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_keep_q  <= '0;
            s2_data_q  <= '0;
            mode_q     <= '0;
            clip_q     <= '0;
            open_q     <= 1'b0;
        end else begin
            if (advance) begin
                s1_valid_q <= accept;
                s1_last_q  <= s_axis_tlast;
                s1_keep_q  <= s_axis_tkeep;
                for (int i = 0; i < LANES; i++) begin
                    s1_data_q[i] <= s0_wide[i];
                end
                s2_valid_q <= s1_valid_q;
                s2_last_q  <= s1_last_q;
                s2_keep_q  <= s1_keep_q;
                s2_data_q  <= s2_data_d;
            end
            if (accept) begin
                if (!open_q) begin
                    mode_q <= activation_mode;
                    clip_q <= clip_value;
                end
                open_q <= !s_axis_tlast;
            end
        end
    end

    assign m_axis_tvalid = s2_valid_q;
    assign m_axis_tdata  = s2_data_q;
    assign m_axis_tkeep  = s2_keep_q;
    assign m_axis_tlast  = s2_last_q;
    assign active_mode   = mode_q;
    assign pkt_open      = open_q;

endmodule

// File: doc/activation_stream_unit.md
Name: activation_stream_unit

Overview:
- Multi-lane, pipelined successor to the single-lane activation stage; sits between the accumulator/requantiser output stream and the next layer's input buffer.
- Applies one of five activation functions to LANES signed two's-complement lanes per AXI-Stream beat, at full throughput with full backpressure.
- Adds features the single-lane stage lacks:
  - activation mode latched per packet;
  - parametrised leaky-ReLU slope;
  - runtime clip level for hard-tanh and clipped ReLU;
  - tkeep pass-through;
  - a 2-stage registered pipeline.

Parameters:
- DATA_WIDTH, 8, width of one signed lane.
- LANES, 4, lanes per beat.
- ALPHA_NUM, 13, leaky slope numerator; must be less than 2**ALPHA_SHIFT.
- ALPHA_SHIFT, 7, leaky slope denominator exponent (alpha = ALPHA_NUM / 2**ALPHA_SHIFT).

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- s_axis_tvalid, input, 1, input beat valid.
- s_axis_tready, output, 1, input beat accepted.
- s_axis_tdata, input, LANES*DATA_WIDTH, lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep, input, LANES, lane-valid mask; passed through unchanged.
- s_axis_tlast, input, 1, last beat of packet.
- activation_mode, input, 3, 0 RELU, 1 LEAKY, 2 HTANH, 3 CLIP_RELU, 4–7 BYPASS.
- clip_value, input, DATA_WIDTH-1, unsigned clip level C for modes 2 and 3.
- m_axis_tvalid, output, 1, output beat valid.
- m_axis_tready, input, 1, downstream ready.
- m_axis_tdata, output, LANES*DATA_WIDTH, activated lanes.
- m_axis_tkeep, output, LANES, delayed s_axis_tkeep.
- m_axis_tlast, output, 1, delayed s_axis_tlast.
- active_mode, output, 3, mode latched for the packet currently entering the pipeline.
- pkt_open, output, 1, high between the first accepted beat and the accepted tlast beat.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on port reset.
  - While reset is high: all stage valids are cleared and s_axis_tready = 0.
- Reset values:
  - m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, active_mode and pkt_open are all 0.
  - Reset mid-packet discards every in-flight beat; no partial beat is emitted afterwards.
- Pipeline:
  - Two stages. S1 registers the raw product/compare results; S2 registers the saturated result.
  - Latency is 2 cycles from acceptance to m_axis_tvalid when not stalled.
  - Throughput is 1 beat per cycle.
- Handshake:
  - advance = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready = advance && !reset.
  - When advance = 0, both stages hold and m_axis_tdata, tkeep and tlast are stable.
  - Bubbles propagate, so a stage's valid may be 0 while the other stage's is 1.
  - No combinational path from s_axis_tvalid to s_axis_tready.
- Mode latching:
  - On an accepted beat with pkt_open = 0, the beat uses the live activation_mode and clip_value; both are stored and active_mode is updated.
  - On an accepted beat with pkt_open = 1, the beat uses the stored values; live changes are ignored.
  - pkt_open sets on an accepted beat with tlast = 0 and clears on an accepted beat with tlast = 1.
  - A single-beat packet uses the live values and leaves pkt_open = 0.
- Per-lane arithmetic (x and y signed DATA_WIDTH, C zero-extended):
  - RELU: y = (x < 0) ? 0 : x.
  - LEAKY:
    - x >= 0: y = x.
    - x < 0: y = (x * ALPHA_NUM) >>> ALPHA_SHIFT.
    - Full-precision product of DATA_WIDTH + clog2(ALPHA_NUM+1) bits; arithmetic shift, which floors.
  - HTANH: y = clamp(x, -C, +C).
  - CLIP_RELU: y = clamp(x, 0, C).
  - BYPASS: y = x.
- Saturation and lanes:
  - Every result is saturated to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1] before the S2 register.
  - Lanes with tkeep = 0 are still computed; tkeep is only forwarded.
- Boundaries:
  - Most-negative input in LEAKY mode yields no overflow.
  - C = 0 in HTANH or CLIP_RELU forces all outputs to 0.
  - Simultaneous input accept and output handshake in the same cycle is a normal pipeline shift, with no loss and no duplication.

Optional Feature:
- Macro: ACT_LEAKY_ROUND_EN.
- Defined: LEAKY negative path uses round-half-up, y = (x*ALPHA_NUM + 2**(ALPHA_SHIFT-1)) >>> ALPHA_SHIFT.
- Undefined: floor, as specified above.
- All other modes are identical in both builds.

Test Plan:
- Values below use the defaults (DATA_WIDTH 8, LANES 4, ALPHA 13/128).
- RELU, 1 beat, lanes {-5, 0, 7, -128}, m_axis_tready=1 -> out {0, 0, 7, 0} exactly 2 cycles after accept; tlast and tkeep echoed.
- LEAKY, lanes {-100, -128, 50, -1}:
  - Without macro -> {-11, -13, 50, -1}.
  - With ACT_LEAKY_ROUND_EN -> {-10, -13, 50, 0}.
- HTANH with C=20, lanes {-100, -20, 19, 127} -> {-20, -20, 19, 20}; CLIP_RELU with C=6, lanes {-3, 4, 6, 90} -> {0, 4, 6, 6}.
- 4-beat packet started in RELU; mode switched to BYPASS at beat 2 -> all 4 beats use RELU and active_mode stays 0; the next packet's first beat uses BYPASS.
- Random m_axis_tready (about 50%) over 200 beats -> output sequence matches a model with no drops or duplicates; data stable while stalled; s_axis_tready low only while the output is stalled.
- reset asserted for 1 cycle with 2 beats in flight -> m_axis_tvalid=0 and pkt_open=0 next cycle; first post-reset beat appears with latency 2.
